// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO for ALU results {sel, carry, out} with sticky overflow.
// Define ALU_FIFO_STATS_EN to add the saturating carry_cnt output.
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_out,
    input  logic                     in_carry,
    input  logic [2:0]               in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef ALU_FIFO_STATS_EN
    ,
    output logic [7:0]               carry_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;

    // Full blocks the push even when a pop happens in the same cycle.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = !w_empty && out_ready;
    assign w_head  = r_mem[r_rd_ptr];

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = w_head;
    assign out_zero  = !w_empty && (w_head[3:0] == 4'b0000);
    assign count     = r_count;
    assign overflow  = r_overflow;

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_push && !rst)
            r_mem[r_wr_ptr] <= {in_sel, in_carry, in_out};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (in_valid && w_full)
                r_overflow <= 1'b1;
        end
    end

`ifdef ALU_FIFO_STATS_EN
    logic [7:0] r_carry_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_carry_cnt <= '0;
        else if (w_push && in_carry && (r_carry_cnt != 8'hFF))
            r_carry_cnt <= r_carry_cnt + 1'b1;
    end

    assign carry_cnt = r_carry_cnt;
`endif

endmodule
